// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, the bundle of
// pipeline-register controls with its canonical settings, and load-use detection.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic ex_mem_write;
        logic mem_wb_write;
        logic pc_src;
        logic if_id_flush;
        logic id_ex_flush;
    } ctrl_t;

    localparam logic [4:0] X0 = 5'd0;

    localparam ctrl_t CTRL_HOLD   = 8'b00000_000;
    localparam ctrl_t CTRL_NORMAL = 8'b11111_000;
    localparam ctrl_t CTRL_FLUSH  = 8'b11111_111;
    localparam ctrl_t CTRL_STALL  = 8'b00111_001;

    // A load in EX whose result the ID instruction needs cannot be forwarded in time.
    function automatic logic detect_load_use(
        input logic       mem_read,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       uses_rs1,
        input logic       uses_rs2
    );
        return mem_read && (rd != X0) &&
               ((uses_rs1 && (rd == rs1)) || (uses_rs2 && (rd == rs2)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the debug event counters.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: hold at all-ones instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline sequencing: memory freeze, branch flush and load-use stall control,
// with a memory-wait watchdog and saturating event counters.
module pipeline_hazard_controller
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IF_ID_RegisterRs1,
    input  logic [4:0]       IF_ID_RegisterRs2,
    input  logic             IF_ID_UsesRs1,
    input  logic             IF_ID_UsesRs2,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_RegisterRd,
    input  logic             EX_Branch,
    input  logic             EX_Zero,
    input  logic             EX_MEM_MemRead,
    input  logic             EX_MEM_MemWrite,
    input  logic             dmem_ready,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             ID_EX_Write,
    output logic             EX_MEM_Write,
    output logic             MEM_WB_Write,
    output logic             PCSrc,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] freeze_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d, wait_cnt_inc_s;
    logic              mem_busy_s, load_use_s, taken_s, frozen_s;
    logic              stall_inc_s, flush_inc_s, freeze_inc_s;
    ctrl_t             ctrl_s, ctrl_out_s;

    // Next state, watchdog count and control bundle, in priority order.
    always_comb begin
        mem_busy_s     = (EX_MEM_MemRead | EX_MEM_MemWrite) & ~dmem_ready;
        load_use_s     = detect_load_use(ID_EX_MemRead, ID_EX_RegisterRd,
                                         IF_ID_RegisterRs1, IF_ID_RegisterRs2,
                                         IF_ID_UsesRs1, IF_ID_UsesRs2);
        taken_s        = EX_Branch & EX_Zero;
        wait_cnt_inc_s = wait_cnt_q + {{(WAIT_W-1){1'b0}}, 1'b1};
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        frozen_s       = 1'b0;
        ctrl_s         = CTRL_HOLD;
        stall_inc_s    = 1'b0;
        flush_inc_s    = 1'b0;
        freeze_inc_s   = 1'b0;

        case (state_q)
            RUN: begin
                frozen_s = mem_busy_s;
                if (mem_busy_s) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = {WAIT_W{1'b0}};
                end else begin
                    state_d = RUN;
                end
            end
            MEM_WAIT: begin
                frozen_s = ~dmem_ready;
                if (dmem_ready) begin
                    state_d = RUN;
                end else if (wait_cnt_inc_s == WAIT_W'(MEM_TIMEOUT)) begin
                    state_d    = ERROR;
                    wait_cnt_d = wait_cnt_inc_s;
                end else begin
                    wait_cnt_d = wait_cnt_inc_s;
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = ERROR;
            end
        endcase

        if (state_q == ERROR) begin
            ctrl_s = CTRL_HOLD;
        end else if (frozen_s) begin
            ctrl_s       = CTRL_HOLD;
            freeze_inc_s = 1'b1;
        end else if (taken_s) begin
            ctrl_s      = CTRL_FLUSH;
            flush_inc_s = 1'b1;
        end else if (load_use_s) begin
            ctrl_s      = CTRL_STALL;
            stall_inc_s = 1'b1;
        end else begin
            ctrl_s = CTRL_NORMAL;
        end
    end

    // State and watchdog registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            wait_cnt_q <= {WAIT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Controls are forced inactive for the whole time reset is held.
    always_comb begin
        if (reset) begin
            ctrl_out_s = CTRL_HOLD;
        end else begin
            ctrl_out_s = ctrl_s;
        end
    end

    assign PCWrite         = ctrl_out_s.pc_write;
    assign IF_ID_Write     = ctrl_out_s.if_id_write;
    assign ID_EX_Write     = ctrl_out_s.id_ex_write;
    assign EX_MEM_Write    = ctrl_out_s.ex_mem_write;
    assign MEM_WB_Write    = ctrl_out_s.mem_wb_write;
    assign PCSrc           = ctrl_out_s.pc_src;
    assign IF_ID_Flush     = ctrl_out_s.if_id_flush;
    assign ID_EX_Flush     = ctrl_out_s.id_ex_flush;
    assign mem_timeout_err = ~reset & (state_q == ERROR);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk(clk), .reset(reset), .inc(stall_inc_s), .count(stall_count)
    );
    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk(clk), .reset(reset), .inc(flush_inc_s), .count(flush_count)
    );
    sat_counter #(.W(CNT_W)) u_freeze_cnt (
        .clk(clk), .reset(reset), .inc(freeze_inc_s), .count(freeze_count)
    );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: directed scenarios plus randomized traffic
// compared every cycle against a cycle-level behavioural model.
module tb_pipeline_hazard_controller;

    localparam int TOUT = 4;
    localparam int CW   = 6;
    localparam int SAT  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    rs1, rs2, ex_rd;
    logic          uses1, uses2, ex_mr, br, zr, mem_rd, mem_wr, rdy;
    logic          o_pcw, o_ifw, o_idw, o_exw, o_mww, o_pcsrc, o_iff, o_idf, o_err;
    logic [CW-1:0] o_stall, o_flush, o_freeze;
    logic [7:0]    got_ctl;

    int n_cmp = 0;
    int n_err = 0;
    int m_stall, m_flush, m_freeze, m_miss, low_left;
    bit m_wait, m_dead;

    pipeline_hazard_controller #(.MEM_TIMEOUT(TOUT), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .IF_ID_RegisterRs1(rs1), .IF_ID_RegisterRs2(rs2),
        .IF_ID_UsesRs1(uses1), .IF_ID_UsesRs2(uses2),
        .ID_EX_MemRead(ex_mr), .ID_EX_RegisterRd(ex_rd),
        .EX_Branch(br), .EX_Zero(zr),
        .EX_MEM_MemRead(mem_rd), .EX_MEM_MemWrite(mem_wr), .dmem_ready(rdy),
        .PCWrite(o_pcw), .IF_ID_Write(o_ifw), .ID_EX_Write(o_idw),
        .EX_MEM_Write(o_exw), .MEM_WB_Write(o_mww), .PCSrc(o_pcsrc),
        .IF_ID_Flush(o_iff), .ID_EX_Flush(o_idf), .mem_timeout_err(o_err),
        .stall_count(o_stall), .flush_count(o_flush), .freeze_count(o_freeze)
    );

    always #5 clk = ~clk;

    assign got_ctl = {o_pcw, o_ifw, o_idw, o_exw, o_mww, o_pcsrc, o_iff, o_idf};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= SAT) ? v : v + 1;
    endfunction

    task automatic model_reset();
        m_stall = 0; m_flush = 0; m_freeze = 0;
        m_wait = 1'b0; m_miss = 0; m_dead = 1'b0;
    endtask

    task automatic set_idle();
        rs1 = 5'd0; rs2 = 5'd0; uses1 = 1'b0; uses2 = 1'b0;
        ex_mr = 1'b0; ex_rd = 5'd0; br = 1'b0; zr = 1'b0;
        mem_rd = 1'b0; mem_wr = 1'b0; rdy = 1'b1;
    endtask

    // Compare this cycle's outputs with the model, then advance the model past the edge.
    task automatic go();
        bit busy, lu, tk, frz;
        logic [7:0] exp_ctl;
        #1;
        busy = (mem_rd || mem_wr) && !rdy;
        lu   = ex_mr && (ex_rd != 5'd0) && ((uses1 && ex_rd == rs1) || (uses2 && ex_rd == rs2));
        tk   = br && zr;
        frz  = !m_dead && (busy || (m_wait && !rdy));
        if (m_dead || frz) exp_ctl = 8'b00000000;
        else if (tk)       exp_ctl = 8'b11111111;
        else if (lu)       exp_ctl = 8'b00111001;
        else               exp_ctl = 8'b11111000;
        check_eq("ctrl", 64'(got_ctl), 64'(exp_ctl));
        check_eq("err", 64'(o_err), 64'(m_dead));
        check_eq("stall_count", 64'(o_stall), 64'(m_stall));
        check_eq("flush_count", 64'(o_flush), 64'(m_flush));
        check_eq("freeze_count", 64'(o_freeze), 64'(m_freeze));
        if (!m_dead) begin
            if (frz)     m_freeze = sat_inc(m_freeze);
            else if (tk) m_flush  = sat_inc(m_flush);
            else if (lu) m_stall  = sat_inc(m_stall);
            if (!m_wait) begin
                if (busy) begin m_wait = 1'b1; m_miss = 0; end
            end else if (rdy) begin
                m_wait = 1'b0;
            end else begin
                m_miss++;
                if (m_miss >= TOUT) m_dead = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        set_idle();
        br = 1'b1; zr = 1'b1;
        #1;
        check_eq("rst_ctrl", 64'(got_ctl), 64'd0);
        check_eq("rst_cnt", 64'({o_stall, o_flush, o_freeze}), 64'd0);
        check_eq("rst_err", 64'(o_err), 64'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        set_idle();
    endtask

    initial begin
        reset = 1'b1;
        set_idle();
        model_reset();
        low_left = 0;
        do_reset();

        // Load x5 then a reader of x5: one bubble.
        @(negedge clk); set_idle(); ex_mr = 1'b1; ex_rd = 5'd5; rs1 = 5'd5; uses1 = 1'b1; go();
        check_eq("lu_ctrl", 64'(got_ctl), 64'b00111001);
        @(negedge clk); set_idle(); go();
        check_eq("lu_stall_cnt", 64'(o_stall), 64'd1);
        // Same with x0 as destination: no stall.
        @(negedge clk); set_idle(); ex_mr = 1'b1; ex_rd = 5'd0; rs2 = 5'd0; uses2 = 1'b1; go();
        check_eq("x0_ctrl", 64'(got_ctl), 64'b11111000);
        // Taken branch overrides a concurrent load-use.
        @(negedge clk); set_idle(); ex_mr = 1'b1; ex_rd = 5'd7; rs2 = 5'd7; uses2 = 1'b1;
        br = 1'b1; zr = 1'b1; go();
        check_eq("br_ctrl", 64'(got_ctl), 64'b11111111);
        @(negedge clk); set_idle(); go();
        check_eq("br_flush_cnt", 64'(o_flush), 64'd1);
        check_eq("br_stall_cnt", 64'(o_stall), 64'd1);

        // Load in MEM with three not-ready cycles.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); set_idle(); mem_rd = 1'b1; rdy = (i == 3); go();
            check_eq("frz_pcw", 64'(o_pcw), (i == 3) ? 64'd1 : 64'd0);
        end
        @(negedge clk); set_idle(); go();
        check_eq("frz_cnt", 64'(o_freeze), 64'd3);

        // Taken branch held in EX during a freeze acts on the release cycle.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); set_idle(); mem_wr = 1'b1; rdy = (i == 2); br = 1'b1; zr = 1'b1; go();
            check_eq("frz_br_pcsrc", 64'(o_pcsrc), (i == 2) ? 64'd1 : 64'd0);
        end

        // Watchdog: never ready leads to a sticky error.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); set_idle(); mem_rd = 1'b1; rdy = (i >= 6); go();
        end
        check_eq("tout_err", 64'(o_err), 64'd1);
        check_eq("tout_ctrl", 64'(got_ctl), 64'd0);

        // Reset asserted between edges in the middle of a freeze.
        do_reset();
        @(negedge clk); set_idle(); mem_rd = 1'b1; rdy = 1'b0; go();
        @(negedge clk); set_idle(); mem_rd = 1'b1; rdy = 1'b0; go();
        #2 reset = 1'b1;
        #1;
        check_eq("mid_rst_ctrl", 64'(got_ctl), 64'd0);
        check_eq("mid_rst_freeze", 64'(o_freeze), 64'd0);
        model_reset();
        @(negedge clk); reset = 1'b0; set_idle(); go();
        check_eq("post_rst_ctrl", 64'(got_ctl), 64'b11111000);

        // Randomized traffic with periodic resets.
        for (int c = 0; c < 2400; c++) begin
            if (c % 400 == 399) do_reset();
            @(negedge clk);
            rs1    = 5'($urandom_range(0, 3));
            rs2    = 5'($urandom_range(0, 3));
            ex_rd  = 5'($urandom_range(0, 3));
            uses1  = 1'($urandom_range(0, 1));
            uses2  = 1'($urandom_range(0, 1));
            ex_mr  = 1'($urandom_range(0, 1));
            br     = 1'($urandom_range(0, 1));
            zr     = 1'($urandom_range(0, 2) == 0);
            mem_rd = 1'($urandom_range(0, 1));
            mem_wr = 1'($urandom_range(0, 3) == 0);
            if (low_left > 0) begin
                rdy = 1'b0;
                low_left--;
            end else if ($urandom_range(0, 14) == 0) begin
                rdy = 1'b0;
                mem_rd = 1'b1;
                low_left = int'($urandom_range(0, 6));
            end else begin
                rdy = 1'($urandom_range(0, 7) != 0);
            end
            go();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
